if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the pipelined RV64 core: owns the program counter, issues requests to instruction memory over a req/ack handshake, buffers returned instructions in a 2-entry fetch queue, and presents the queue head to the IF/ID pipeline register. The queue head is consumed on any rising edge where `stall` is low. A taken branch/jump (`redirect`) flushes the queue, squashes any in-flight fetch, and restarts fetch at `redirect_pc`.

## Interface
Parameters:
- `RESET_PC`, 64'h0, first fetch address after reset
- `QDEPTH`, 2, fetch queue depth (fixed at 2; parameter exists for the sub-module only)

Ports:
- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `stall`  input  1  hazard stall, same signal that freezes IF/ID; low = head consumed this edge
- `redirect`  input  1  branch taken / jump resolved; one-cycle pulse
- `redirect_pc`  input  64  target address, valid with `redirect`
- `imem_req`  output  1  fetch request outstanding
- `imem_addr`  output  64  address of outstanding request, stable while `imem_req` high
- `imem_ack`  input  1  response valid; ignored when `imem_req` low
- `imem_rdata`  input  32  instruction word, valid with `imem_ack`
- `PCOut`  output  64  PC of queue head
- `instruction`  output  32  queue head instruction, or NOP when queue empty
- `fetch_valid`  output  1  queue non-empty

## Operation
- FSM states: IDLE (no request), WAIT (request outstanding), SQUASH (outstanding request whose response is discarded).
- IDLE -> WAIT when queue count after this edge's pop is < 2; `imem_addr` <= `pc`.
- WAIT, `imem_ack`=1: push {`imem_addr`, `imem_rdata`}; `pc` <= `imem_addr` + 4; stay WAIT with new address if post-push/pop count < 2, else IDLE.
- WAIT, `imem_ack`=0: hold; `imem_addr` unchanged.
- SQUASH: `imem_req` high at the squashed address; on `imem_ack` discard data, go WAIT at current `pc` (IDLE rule applies: queue empty after flush).
- `redirect` has priority over ack, pop, and stall: queue flushed (count=0), `pc` <= `redirect_pc`. WAIT without ack -> SQUASH; WAIT with ack same cycle -> data dropped, go WAIT at `redirect_pc`; SQUASH -> stays SQUASH, `pc` updated; IDLE -> WAIT at `redirect_pc`.
- Pop: head removed on edge with `stall`=0 and count>0. Push and pop on the same edge allowed.
- Queue can never overflow: only one request outstanding; issue only when a free slot is guaranteed.
- PC arithmetic is 64-bit unsigned, +4, wraps modulo 2^64 with no error.
- Empty queue: `fetch_valid`=0, `instruction`=32'h00000013, `PCOut`=0.

## Timing
- Reset (async): state IDLE, `pc`=`RESET_PC`, queue empty, `imem_req`=0, `imem_addr`=0, `PCOut`=0, `instruction`=NOP, `fetch_valid`=0.
- First `imem_req` is high in the cycle after the first rising edge following reset release.
- Ack may arrive in the same cycle `imem_req` rises (zero-wait) or any number of cycles later.
- Zero-wait memory, no stall: one instruction per cycle. Data acked at edge N is at the queue head/output after edge N (ack-to-output latency 1).
- Outputs are registered; no combinational path from `imem_*` or `stall` to `PCOut`/`instruction`/`fetch_valid`.
- `redirect` at edge N: `fetch_valid`=0 after N. If no squash is pending, `imem_addr`=`redirect_pc` after N.
- Reset mid-request: the memory side must tolerate `imem_req` dropping without an ack.

## Structure
- Shared package: `NOP_INSTR`=32'h00000013, `PC_INCR`=4, FSM state enum (IDLE/WAIT/SQUASH).
- Sub-module `fetch_queue`: 2-entry FIFO of {pc[63:0], instr[31:0]} with push, pop, flush, count, head outputs; flush overrides push.

## Test plan
- Reset, zero-wait memory returning `addr`-derived words, `stall`=0 -> PCOut 0,4,8,12 on consecutive cycles, one per cycle.
- `stall` held 5 cycles with zero-wait memory -> queue fills to 2, `imem_req` drops to 0, head stays PC=0; stall release -> 4, 8 follow with no gap or duplicate.
- Memory latency 3 cycles -> `imem_addr` stable while waiting, `fetch_valid` low between instructions, PCs sequential.
- `redirect`=1, `redirect_pc`=64'h100 while request for 64'h8 outstanding (ack 2 cycles later) -> 64'h8 data discarded, next `imem_addr`=64'h100, first valid PCOut=64'h100.
- `redirect` on the same edge as ack and `stall`=0 pop -> acked data dropped, queue empty, `imem_addr`=`redirect_pc` next cycle.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 64'h0; async `reset` pulse mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, FSM state and fetch-queue entry type for the fetch stage
package if_fetch_unit_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [63:0] PC_INCR   = 64'd4;
    typedef enum logic [1:0] {IDLE, WAIT, SQUASH} fetch_state_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr} between instruction memory and IF/ID
// Ports: clk, reset (async, active-high); push/din write an entry, pop drops the head,
// flush empties the queue and overrides push/pop; count and head describe the current contents.
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  fq_entry_t din,
    output logic [1:0] count,
    output fq_entry_t head
);
    fq_entry_t  mem [QDEPTH];
    logic [1:0] slot;
    // A simultaneous pop frees the head first, so the new entry lands one slot lower.
    assign slot = count - {1'b0, pop};
    assign head = mem[0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            mem   <= '{default: '0};
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) mem[0] <= mem[1];
            if (push) mem[slot[0]] <= din;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV64 instruction-fetch stage with PC, imem req/ack handshake and 2-entry queue
// Ports: clk, reset (async, active-high); stall/redirect/redirect_pc from the pipeline;
// imem_req/imem_addr/imem_ack/imem_rdata to instruction memory; PCOut/instruction/fetch_valid
// present the queue head to IF/ID (NOP and PC 0 when empty).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] PCOut,
    output logic [31:0] instruction,
    output logic        fetch_valid
);
    localparam logic [1:0] QMAX = 2'(QDEPTH);
    fetch_state_t state, state_d;
    logic [63:0]  pc, pc_d, addr_d, nxt;
    logic [1:0]   count, post;
    logic         acked, push, pop, room, issue;
    fq_entry_t    din, head;
    assign acked = imem_ack && state != IDLE;
    // Redirect flushes the queue, so neither the acked word nor the pop survive it.
    assign push  = acked && state == WAIT && !redirect;
    assign pop   = !stall && count != '0 && !redirect;
    assign post  = count + {1'b0, push} - {1'b0, pop};
    // A new request is only issued when its response is guaranteed a free slot.
    assign room  = redirect || post < QMAX;
    assign issue = room && (state == IDLE || acked);
    assign nxt   = redirect ? redirect_pc : state == WAIT ? imem_addr + PC_INCR : pc;
    always_comb begin
        state_d = issue ? WAIT : acked ? IDLE : (redirect && state == WAIT) ? SQUASH : state;
        addr_d  = issue ? nxt : imem_addr;
        pc_d    = redirect ? redirect_pc : push ? imem_addr + PC_INCR : pc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_addr <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            imem_addr <= addr_d;
        end
    end
    assign imem_req = state != IDLE;
    assign din      = {imem_addr, imem_rdata};
    fetch_queue #(.QDEPTH(QDEPTH)) u_fq (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .count (count),
        .head  (head)
    );
    assign fetch_valid = count != '0;
    assign PCOut       = fetch_valid ? head.pc : '0;
    assign instruction = fetch_valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    logic        clk = 0, reset = 0, stall = 0, redirect = 0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req, imem_ack, fetch_valid;
    logic [63:0] imem_addr, PCOut;
    logic [31:0] imem_rdata, instruction;
    logic        req2, valid2;
    logic [63:0] addr2, pc2;
    logic [31:0] instr2, rdata2;
    int          lat = 0, wcnt = 0, n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    // memory model: acks once the request has been held for lat cycles (lat=0 is zero-wait)
    assign imem_ack   = imem_req && wcnt >= lat;
    assign imem_rdata = instr_of(imem_addr);
    always @(posedge clk) wcnt <= (!imem_req || imem_ack) ? 0 : wcnt + 1;
    assign rdata2 = instr_of(addr2);

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PCOut(PCOut), .instruction(instruction), .fetch_valid(fetch_valid)
    );

    if_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0), .redirect_pc(64'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
        .PCOut(pc2), .instruction(instr2), .fetch_valid(valid2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_valid"}, fetch_valid, 0);
        chk({tag, "_instr"}, instruction, 32'h0000_0013);
        chk({tag, "_pcout"}, PCOut, 0);
        chk({tag, "_valid2"}, valid2, 0);
    endtask

    initial begin
        #1 reset = 1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 0;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_valid", fetch_valid, 0);
        // zero-wait streaming, one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_pc", PCOut, 64'(4 * i));
            chk("seq_instr", instruction, instr_of(64'(4 * i)));
            chk("seq_valid", fetch_valid, 1);
            if (i == 0) begin
                chk("wrap_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("wrap_addr", addr2, 0);
            end
            if (i == 1) chk("wrap_next", pc2, 0);
        end
        // stall: queue fills, request drops, head frozen
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", PCOut, 12);
            chk("stall_req", imem_req, 0);
        end
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("resume_pc", PCOut, 64'(16 + 4 * i));
            chk("resume_valid", fetch_valid, 1);
        end
        // 3-cycle latency memory
        lat = 3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("lat_addr", imem_addr, k < 4 ? 64'd28 : k < 8 ? 64'd32 : 64'd36);
            chk("lat_valid", fetch_valid, (k == 4 || k == 8) ? 64'd1 : 64'd0);
            if (k == 4 || k == 8) chk("lat_pc", PCOut, k == 4 ? 64'd28 : 64'd32);
        end
        // redirect while the request for 36 is outstanding: its data must be discarded
        redirect = 1;
        redirect_pc = 64'h100;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            redirect = 0;
            chk("sq_addr", imem_addr, k < 4 ? 64'd36 : k < 8 ? 64'h100 : 64'h104);
            chk("sq_valid", fetch_valid, k == 8 ? 64'd1 : 64'd0);
            chk("sq_req", imem_req, 1);
        end
        chk("sq_pc", PCOut, 64'h100);
        chk("sq_instr", instruction, instr_of(64'h100));
        // redirect on the same edge as ack and pop
        lat = 0;
        @(negedge clk);
        chk("pre_rd_pc", PCOut, 64'h104);
        redirect = 1;
        redirect_pc = 64'h2000;
        @(negedge clk);
        redirect = 0;
        chk("rd_valid", fetch_valid, 0);
        chk("rd_addr", imem_addr, 64'h2000);
        chk("rd_req", imem_req, 1);
        chk("rd_instr", instruction, 32'h0000_0013);
        chk("rd_pcout", PCOut, 0);
        @(negedge clk);
        chk("rd_first", PCOut, 64'h2000);
        chk("rd_first_valid", fetch_valid, 1);
        @(negedge clk);
        chk("rd_next", PCOut, 64'h2004);
        // asynchronous reset while a request is pending
        lat = 5;
        chk("pre_rst_valid", fetch_valid, 1);
        chk("pre_rst_req", imem_req, 1);
        #2 reset = 1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
